lut_decoder_sequencer: RTL and testbench

//  Sequencer directly upstream of lut_decoder in the BKM FPU datapath.
//  - On start, sweeps BKM iteration index n = 0..N-1 onto lut_n; lut_decoder returns that row combinationally.
//  - Registers each decoded row (X_n/Y_n in CSD, u_n/v_n binary) into a 2-entry buffer.
//  - Streams rows to the BKM iteration stage over a valid/ready handshake.

---
 rtl/lut_decoder_sequencer_pkg.sv | 9 +
 rtl/lut_decoder_sequencer_lut_row_fifo2.sv | 40 ++++
 rtl/lut_decoder_sequencer.sv | 78 +++++++
 tb/tb_lut_decoder_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lut_decoder_sequencer_pkg.sv
// lut_decoder_sequencer_pkg: shared widths, sweep length and FSM encodings for the LUT sequencer.
package lut_decoder_sequencer_pkg;
  localparam int WD = 73;
  localparam int WC = 21;
  localparam int WI = 11;
  localparam int N  = 64;
  localparam int WN = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
endpackage

// File: rtl/lut_decoder_sequencer_lut_row_fifo2.sv
// lut_row_fifo2: 2-entry register FIFO, head always in m0_q so the output needs no mux.
module lut_row_fifo2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         srst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] m0_q, m0_d, m1_q, m1_d;
  logic [1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= '0;
    end else if (srst) begin
      m0_q  <= '0;
      m1_q  <= '0;
      cnt_q <= '0;
    end else if (en) begin
      m0_q  <= m0_d;
      m1_q  <= m1_d;
      cnt_q <= cnt_d;
    end
  // a pop that empties the FIFO leaves m0 untouched so the idle head stays stable
  always_comb begin
    m0_d  = (pop && cnt_q == 2'd2) ? m1_q :
            (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? din : m0_q;
    m1_d  = (push && (cnt_q == 2'd2 || (!pop && cnt_q == 2'd1))) ? din : m1_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end
  assign dout  = m0_q;
  assign count = cnt_q;
endmodule

// File: rtl/lut_decoder_sequencer.sv
// lut_decoder_sequencer: sweeps lut_n over 0..N-1, buffers decoded rows in a 2-deep FIFO
// and streams them downstream over valid/ready.
import lut_decoder_sequencer_pkg::*;
module lut_decoder_sequencer (
  input  logic            clk,
  input  logic            arst,
  input  logic            srst,
  input  logic            enable,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [WN-1:0]   lut_n,
  input  logic [2*WD-1:0] lut_X_n_csd,
  input  logic [2*WD-1:0] lut_Y_n_csd,
  input  logic [WC-1:0]   lut_u_n_bin,
  input  logic [WC-1:0]   lut_v_n_bin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*WD-1:0] out_X_n_csd,
  output logic [2*WD-1:0] out_Y_n_csd,
  output logic [WC-1:0]   out_u_n_bin,
  output logic [WC-1:0]   out_v_n_bin,
  output logic [WN-1:0]   out_n,
  output logic            out_last
);
  localparam int PW = 4*WD + 2*WC + WN + 1;
  state_e state_q, state_d;
  logic [WN-1:0] lut_n_q, lut_n_d;
  logic [1:0] count;
  logic push, pop, last_row;
  logic [PW-1:0] head;
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state_q <= IDLE;
      lut_n_q <= '0;
    end else if (srst) begin
      state_q <= IDLE;
      lut_n_q <= '0;
    end else if (enable) begin
      state_q <= state_d;
      lut_n_q <= lut_n_d;
    end
  // push never looks at out_ready, so there is no combinational ready path
  always_comb begin
    push     = state_q == RUN && count != 2'd2;
    last_row = lut_n_q == WN'(N - 1);
    state_d  = state_q;
    lut_n_d  = push ? lut_n_q + 1'b1 : lut_n_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (push && last_row) ? DRAIN : RUN;
      DRAIN: begin
        state_d = count == 2'd0 ? IDLE : DRAIN;
        lut_n_d = count == 2'd0 ? '0 : lut_n_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy      = state_q != IDLE;
    done      = enable && !srst && state_q == DRAIN && count == 2'd0;
    out_valid = count != 2'd0;
    pop       = out_valid && out_ready;
    lut_n     = lut_n_q;
    {out_X_n_csd, out_Y_n_csd, out_u_n_bin, out_v_n_bin, out_n, out_last} = head;
  end
  lut_row_fifo2 #(.W(PW)) u_fifo (
    .clk   (clk),
    .arst  (arst),
    .srst  (srst),
    .en    (enable),
    .push  (push),
    .pop   (pop),
    .din   ({lut_X_n_csd, lut_Y_n_csd, lut_u_n_bin, lut_v_n_bin, lut_n_q, last_row}),
    .dout  (head),
    .count (count)
  );
endmodule

// File: tb/tb_lut_decoder_sequencer.sv
// tb_lut_decoder_sequencer: randomized valid/ready/enable stimulus against a row-ordering
// scoreboard and a behavioural decoder model.
import lut_decoder_sequencer_pkg::*;
module tb_lut_decoder_sequencer;
  logic clk, arst, srst, enable, start, out_ready;
  logic busy, done, out_valid, out_last;
  logic [WN-1:0] lut_n, out_n;
  logic [2*WD-1:0] lut_X_n_csd, lut_Y_n_csd, out_X_n_csd, out_Y_n_csd;
  logic [WC-1:0] lut_u_n_bin, lut_v_n_bin, out_u_n_bin, out_v_n_bin;
  int errors = 0, checks = 0;
  int exp_n, dones, cyc, first_valid, done_cyc;
  logic [31:0] salt;
  logic hold_chk;
  logic [383:0] held;

  function automatic logic [2*WD-1:0] mx(input int n);
    return ((2*WD)'(n) * (2*WD)'(3)) ^ ((2*WD)'(salt) << 100);
  endfunction
  function automatic logic [2*WD-1:0] my(input int n);
    return ~(2*WD)'(n) ^ ((2*WD)'(salt) << 20);
  endfunction
  function automatic logic [WC-1:0] mu(input int n);
    return WC'(n);
  endfunction
  function automatic logic [WC-1:0] mv(input int n);
    return WC'(n) ^ salt[WC-1:0];
  endfunction

  assign lut_X_n_csd = mx(int'(lut_n));
  assign lut_Y_n_csd = my(int'(lut_n));
  assign lut_u_n_bin = mu(int'(lut_n));
  assign lut_v_n_bin = mv(int'(lut_n));

  lut_decoder_sequencer dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .start(start),
    .busy(busy), .done(done), .lut_n(lut_n),
    .lut_X_n_csd(lut_X_n_csd), .lut_Y_n_csd(lut_Y_n_csd),
    .lut_u_n_bin(lut_u_n_bin), .lut_v_n_bin(lut_v_n_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_X_n_csd(out_X_n_csd), .out_Y_n_csd(out_Y_n_csd),
    .out_u_n_bin(out_u_n_bin), .out_v_n_bin(out_v_n_bin),
    .out_n(out_n), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [383:0] head_now();
    return 384'({out_X_n_csd, out_Y_n_csd, out_u_n_bin, out_v_n_bin, out_n, out_last});
  endfunction

  task automatic check_zero(input string tag);
    check(tag, {busy, done, out_valid, lut_n, head_now()}, '0);
  endtask

  // one clock: drive, settle, score the cycle, then move just past the next edge
  task automatic step(input logic st, input logic rdy, input logic en);
    start = st;
    out_ready = rdy;
    enable = en;
    #1;
    if (hold_chk) check("stable", head_now(), held);
    if (out_valid && rdy && en && !srst) begin
      check("out_n", out_n, exp_n);
      check("row", {out_X_n_csd, out_Y_n_csd, out_u_n_bin, out_v_n_bin},
            {mx(exp_n), my(exp_n), mu(exp_n), mv(exp_n)});
      check("last", out_last, exp_n == N - 1);
      exp_n++;
    end
    hold_chk = out_valid && !(rdy && en) && !srst;
    held = head_now();
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (out_valid && first_valid < 0) first_valid = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_sweep();
    salt = $urandom;
    exp_n = 0;
    dones = 0;
    cyc = 0;
    first_valid = -1;
    done_cyc = -1;
    hold_chk = 1'b0;
  endtask

  task automatic run_to_done(input int budget, input bit rnd_rdy, input bit rnd_en, input bit spam);
    int g = 0;
    while (dones == 0 && g < budget) begin
      step(spam, rnd_rdy ? ($urandom % 4 != 0) : 1'b1, rnd_en ? ($urandom % 5 != 0) : 1'b1);
      g++;
    end
    if (dones == 0) check("timeout", 0, 1);
    step(1'b0, 1'b1, 1'b1);
    check("rows", exp_n, N);
    check("dones", dones, 1);
    check("idle", {busy, out_valid, lut_n}, 0);
  endtask

  initial begin
    int g, ln, en_snap;
    arst = 1'b1; srst = 1'b0; enable = 1'b0; start = 1'b0; out_ready = 1'b0;
    salt = '0; hold_chk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    arst = 1'b0;

    // full-rate sweep: latency and done timing
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    run_to_done(200, 0, 0, 0);
    check("first_valid", first_valid, 2);
    check("done_cyc", done_cyc, N + 2);

    // async reset in the middle of a sweep, then a clean restart
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    g = 0;
    while (lut_n != WN'(10) && g < 50) begin step(1'b0, 1'b1, 1'b1); g++; end
    check("reach_n10", lut_n, 10);
    arst = 1'b1;
    #1;
    check_zero("arst_mid");
    #2;
    arst = 1'b0;
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    run_to_done(200, 0, 0, 0);

    // downstream stall right after start
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    check("stall_lut_n", lut_n, 2);
    check("stall_head", {out_valid, out_n}, {1'b1, WN'(0)});
    run_to_done(200, 0, 0, 0);

    // enable low freezes everything mid-sweep
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1, 1'b1);
    ln = int'(lut_n);
    en_snap = exp_n;
    repeat (3) step(1'b0, 1'b1, 1'b0);
    check("frozen_lut_n", lut_n, ln);
    check("frozen_pops", exp_n, en_snap);
    run_to_done(200, 0, 0, 0);

    // start held high throughout, including the done cycle
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    run_to_done(200, 0, 0, 1);

    // sync clear overrides enable mid-sweep
    begin_sweep();
    step(1'b1, 1'b1, 1'b1);
    repeat (7) step(1'b0, 1'b0, 1'b1);
    srst = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    srst = 1'b0;
    hold_chk = 1'b0;
    check_zero("srst_mid");

    // randomized ready/enable with start spam
    for (int s = 0; s < 4; s++) begin
      begin_sweep();
      step(1'b1, 1'b1, 1'b1);
      run_to_done(2000, 1, 1, s[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
